// File: rtl/hazard_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// hazard_ctrl_pkg
// Shared definitions for the pipeline hazard sequencer:
//   - hz_state_t   : sequencer FSM state encoding (also exported as debug port)
//   - hz_ctrl_t    : bundle of pipeline control outputs
//   - CTRL_*       : canned control bundles for each hazard response
//   - vector / register constants used by the surrounding MIPS core
// -----------------------------------------------------------------------------
package hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_LU_STALL = 2'd1,
        ST_MEM_WAIT = 2'd2,
        ST_IRQ_HOLD = 2'd3
    } hz_state_t;

    localparam logic [31:0] IRQ_VECTOR = 32'h8000_0004;
    localparam logic [31:0] EXC_VECTOR = 32'h8000_0008;
    localparam logic [4:0]  REG_K0     = 5'd26;
    localparam logic [4:0]  REG_RA     = 5'd31;

    typedef struct packed {
        logic pc_write;
        logic if_id_write;
        logic if_id_flush;
        logic id_ex_flush;
        logic ex_mem_hold;
        logic mem_wb_flush;
        logic irq_take;
        logic bus_err;
    } hz_ctrl_t;

    // Normal flow: PC and IF/ID advance, nothing squashed.
    localparam hz_ctrl_t CTRL_DEFAULT = '{pc_write: 1'b1, if_id_write: 1'b1, default: 1'b0};

    // Memory not ready: freeze front end and EX/MEM (ID/EX follows ex_mem_hold),
    // and push a bubble into WB so the pending access is not retired twice.
    localparam hz_ctrl_t CTRL_MEM_STALL = '{ex_mem_hold: 1'b1, mem_wb_flush: 1'b1, default: 1'b0};

    // Taken branch in EX: squash the two younger instructions.
    localparam hz_ctrl_t CTRL_BRANCH = '{pc_write: 1'b1, if_id_write: 1'b1, if_id_flush: 1'b1,
                                         id_ex_flush: 1'b1, default: 1'b0};

    // Load-use: hold PC and IF/ID, insert one bubble into EX.
    localparam hz_ctrl_t CTRL_LU_STALL = '{id_ex_flush: 1'b1, default: 1'b0};

endpackage

// File: rtl/hazard_ctrl_hazard_detect.sv
// -----------------------------------------------------------------------------
// hazard_detect
// Combinational load-use hazard compare between the load in EX and the
// source registers of the instruction in ID. $0 is never a real dependency.
// Ports:
//   id_valid        in  ID holds a real instruction
//   id_rs, id_rt    in  ID source registers
//   id_uses_rt      in  ID instruction actually reads Rt
//   id_ex_memread   in  EX instruction is a load
//   id_ex_writereg  in  EX destination register
//   lu_hazard       out load-use hazard present
// -----------------------------------------------------------------------------
module hazard_detect (
    input  logic       id_valid,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_uses_rt,
    input  logic       id_ex_memread,
    input  logic [4:0] id_ex_writereg,
    output logic       lu_hazard
);

    logic [4:0] rs_eq_bits;
    logic [4:0] rt_eq_bits;
    logic       rs_match;
    logic       rt_match;
    logic       dest_nonzero;

    genvar gi;
    generate
        for (gi = 0; gi < 5; gi++) begin : g_cmp
            assign rs_eq_bits[gi] = id_ex_writereg[gi] ~^ id_rs[gi];
            assign rt_eq_bits[gi] = id_ex_writereg[gi] ~^ id_rt[gi];
        end
    endgenerate

    assign rs_match     = &rs_eq_bits;
    assign rt_match     = (&rt_eq_bits) & id_uses_rt;
    assign dest_nonzero = |id_ex_writereg;

    assign lu_hazard = id_valid & id_ex_memread & dest_nonzero & (rs_match | rt_match);

endmodule

// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
// Central stall/flush sequencer for the 5-stage MIPS pipeline. Handles the
// hazards forwarding cannot cover: load-use, taken branches (EX), jumps (ID),
// multi-cycle memory waits with timeout, and interrupt entry.
// Ports:
//   clk, reset_b       clock, asynchronous active-low reset
//   id_*               instruction in ID (valid, sources, jump)
//   id_ex_*            load/destination info of instruction in EX
//   ex_branch_taken    branch in EX resolved taken
//   mem_req/mem_ready  MEM-stage access handshake
//   irq_req/irq_enable level interrupt request / interrupts allowed
//   cnt_clr            synchronous clear of stall_cycles
//   pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_hold,
//   mem_wb_flush       pipeline register controls
//   irq_take           one-cycle interrupt entry
//   bus_err            one-cycle memory timeout pulse
//   state              FSM state (debug)
//   stall_cycles       saturating count of cycles with pc_write=0
// -----------------------------------------------------------------------------
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int MAX_WAIT = 16,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset_b,
    input  logic             id_valid,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             id_jump,
    input  logic             id_ex_memread,
    input  logic [4:0]       id_ex_writereg,
    input  logic             ex_branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    input  logic             irq_req,
    input  logic             irq_enable,
    input  logic             cnt_clr,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             ex_mem_hold,
    output logic             mem_wb_flush,
    output logic             irq_take,
    output logic             bus_err,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam int WAIT_W = $clog2(MAX_WAIT + 1);

    hz_state_t         state_reg;
    hz_state_t         state_next;
    logic [WAIT_W-1:0] wait_cnt_reg;
    logic [WAIT_W-1:0] wait_cnt_next;
    logic [CNT_W-1:0]  stall_cnt_reg;
    hz_ctrl_t          ctrl;

    logic lu_hazard;
    logic mem_stall;
    logic irq_ok;

    hazard_detect u_hazard_detect (
        .id_valid       (id_valid),
        .id_rs          (id_rs),
        .id_rt          (id_rt),
        .id_uses_rt     (id_uses_rt),
        .id_ex_memread  (id_ex_memread),
        .id_ex_writereg (id_ex_writereg),
        .lu_hazard      (lu_hazard)
    );

    assign mem_stall = mem_req & ~mem_ready;
    // Taking an IRQ on a bubble or a jump would save the wrong return PC,
    // so entry is deferred until a plain instruction sits in ID.
    assign irq_ok    = irq_req & irq_enable & id_valid & ~id_jump;

    always_comb begin
        ctrl          = CTRL_DEFAULT;
        state_next    = state_reg;
        wait_cnt_next = wait_cnt_reg;

        case (state_reg)
            ST_RUN: begin
                if (mem_stall) begin
                    ctrl          = CTRL_MEM_STALL;
                    state_next    = ST_MEM_WAIT;
                    wait_cnt_next = WAIT_W'(1);
                end else if (ex_branch_taken) begin
                    ctrl = CTRL_BRANCH;
                end else if (irq_ok) begin
                    ctrl.irq_take    = 1'b1;
                    ctrl.if_id_flush = 1'b1;
                    state_next       = ST_IRQ_HOLD;
                end else if (lu_hazard) begin
                    ctrl       = CTRL_LU_STALL;
                    state_next = ST_LU_STALL;
                end else if (id_jump) begin
                    ctrl.if_id_flush = 1'b1;
                end
            end

            // EX holds the bubble we inserted, so only memory and branch
            // events can matter for this single cycle.
            ST_LU_STALL: begin
                state_next = ST_RUN;
                if (mem_stall) begin
                    ctrl          = CTRL_MEM_STALL;
                    state_next    = ST_MEM_WAIT;
                    wait_cnt_next = WAIT_W'(1);
                end else if (ex_branch_taken) begin
                    ctrl = CTRL_BRANCH;
                end
            end

            ST_MEM_WAIT: begin
                if (mem_ready) begin
                    state_next    = ST_RUN;
                    wait_cnt_next = '0;
                end else if (wait_cnt_reg >= WAIT_W'(MAX_WAIT)) begin
                    // Abandon the access: release the pipeline, bubble WB.
                    ctrl.bus_err      = 1'b1;
                    ctrl.mem_wb_flush = 1'b1;
                    state_next        = ST_RUN;
                    wait_cnt_next     = '0;
                end else begin
                    ctrl          = CTRL_MEM_STALL;
                    wait_cnt_next = wait_cnt_reg + WAIT_W'(1);
                end
            end

            // Interrupt entry in flight: block further IRQs until the core is
            // running kernel code (irq_enable drops). Normal hazards still apply;
            // a load-use stall here is resolved in place without leaving the state.
            ST_IRQ_HOLD: begin
                if (mem_stall) begin
                    ctrl          = CTRL_MEM_STALL;
                    state_next    = ST_MEM_WAIT;
                    wait_cnt_next = WAIT_W'(1);
                end else begin
                    if (!irq_enable) begin
                        state_next = ST_RUN;
                    end
                    if (ex_branch_taken) begin
                        ctrl = CTRL_BRANCH;
                    end else if (lu_hazard) begin
                        ctrl = CTRL_LU_STALL;
                    end else if (id_jump) begin
                        ctrl.if_id_flush = 1'b1;
                    end
                end
            end

            default: begin
                state_next    = ST_RUN;
                wait_cnt_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state_reg    <= ST_RUN;
            wait_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
        end
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            stall_cnt_reg <= '0;
        end else if (cnt_clr) begin
            stall_cnt_reg <= '0;
        end else if (!ctrl.pc_write && (stall_cnt_reg != {CNT_W{1'b1}})) begin
            stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
        end
    end

    assign pc_write     = ctrl.pc_write;
    assign if_id_write  = ctrl.if_id_write;
    assign if_id_flush  = ctrl.if_id_flush;
    assign id_ex_flush  = ctrl.id_ex_flush;
    assign ex_mem_hold  = ctrl.ex_mem_hold;
    assign mem_wb_flush = ctrl.mem_wb_flush;
    assign irq_take     = ctrl.irq_take;
    assign bus_err      = ctrl.bus_err;
    assign state        = state_reg;
    assign stall_cycles = stall_cnt_reg;

endmodule

// File: tb/tb_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl
// Directed-vector bench for hazard_ctrl with a rule-level reference model
// evaluated every cycle, plus hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_hazard_ctrl;

    localparam int MAX_WAIT = 4;
    localparam int CNT_W    = 16;

    logic             clk = 1'b0;
    logic             reset_b;
    logic             id_valid;
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic             id_uses_rt;
    logic             id_jump;
    logic             id_ex_memread;
    logic [4:0]       id_ex_writereg;
    logic             ex_branch_taken;
    logic             mem_req;
    logic             mem_ready;
    logic             irq_req;
    logic             irq_enable;
    logic             cnt_clr;
    logic             pc_write;
    logic             if_id_write;
    logic             if_id_flush;
    logic             id_ex_flush;
    logic             ex_mem_hold;
    logic             mem_wb_flush;
    logic             irq_take;
    logic             bus_err;
    logic [1:0]       state;
    logic [CNT_W-1:0] stall_cycles;

    always #5 clk = ~clk;

    hazard_ctrl #(.MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
        .clk             (clk),
        .reset_b         (reset_b),
        .id_valid        (id_valid),
        .id_rs           (id_rs),
        .id_rt           (id_rt),
        .id_uses_rt      (id_uses_rt),
        .id_jump         (id_jump),
        .id_ex_memread   (id_ex_memread),
        .id_ex_writereg  (id_ex_writereg),
        .ex_branch_taken (ex_branch_taken),
        .mem_req         (mem_req),
        .mem_ready       (mem_ready),
        .irq_req         (irq_req),
        .irq_enable      (irq_enable),
        .cnt_clr         (cnt_clr),
        .pc_write        (pc_write),
        .if_id_write     (if_id_write),
        .if_id_flush     (if_id_flush),
        .id_ex_flush     (id_ex_flush),
        .ex_mem_hold     (ex_mem_hold),
        .mem_wb_flush    (mem_wb_flush),
        .irq_take        (irq_take),
        .bus_err         (bus_err),
        .state           (state),
        .stall_cycles    (stall_cycles)
    );

    typedef struct packed {
        logic       id_valid;
        logic [4:0] id_rs;
        logic [4:0] id_rt;
        logic       id_uses_rt;
        logic       id_jump;
        logic       id_ex_memread;
        logic [4:0] id_ex_writereg;
        logic       ex_branch_taken;
        logic       mem_req;
        logic       mem_ready;
        logic       irq_req;
        logic       irq_enable;
        logic       cnt_clr;
    } vec_t;

    typedef struct packed {
        logic       pc_write;
        logic       if_id_write;
        logic       if_id_flush;
        logic       id_ex_flush;
        logic       ex_mem_hold;
        logic       mem_wb_flush;
        logic       irq_take;
        logic       bus_err;
        logic [1:0] state;
    } obs_t;

    int checks   = 0;
    int failures = 0;
    int cyc_no   = 0;

    // Reference model: pipeline mode (0 run, 1 load-use, 2 mem wait, 3 irq hold)
    int   m_mode, m_waited, m_stalls;
    int   nxt_mode, nxt_waited;
    obs_t exp_o, got_o, snap;

    task automatic drive(input vec_t vi);
        id_valid        = vi.id_valid;
        id_rs           = vi.id_rs;
        id_rt           = vi.id_rt;
        id_uses_rt      = vi.id_uses_rt;
        id_jump         = vi.id_jump;
        id_ex_memread   = vi.id_ex_memread;
        id_ex_writereg  = vi.id_ex_writereg;
        ex_branch_taken = vi.ex_branch_taken;
        mem_req         = vi.mem_req;
        mem_ready       = vi.mem_ready;
        irq_req         = vi.irq_req;
        irq_enable      = vi.irq_enable;
        cnt_clr         = vi.cnt_clr;
    endtask

    task automatic model_reset();
        m_mode   = 0;
        m_waited = 0;
        m_stalls = 0;
    endtask

    // Decide what the pipeline must do this cycle from the hazard rules.
    task automatic model_eval();
        bit lu, mw, fr_mem, fr_lu, sq_if, sq_id, take, err;
        lu = id_valid && id_ex_memread && (id_ex_writereg != 0) &&
             ((id_ex_writereg == id_rs) || (id_uses_rt && (id_ex_writereg == id_rt)));
        mw = mem_req && !mem_ready;
        fr_mem = 0; fr_lu = 0; sq_if = 0; sq_id = 0; take = 0; err = 0;
        nxt_mode   = m_mode;
        nxt_waited = m_waited;
        if (m_mode == 2) begin
            if (mem_ready) begin
                nxt_mode = 0; nxt_waited = 0;
            end else if (m_waited >= MAX_WAIT) begin
                err = 1; nxt_mode = 0; nxt_waited = 0;
            end else begin
                fr_mem = 1; nxt_waited = m_waited + 1;
            end
        end else if (mw) begin
            fr_mem = 1; nxt_mode = 2; nxt_waited = 1;
        end else begin
            if (m_mode == 1) nxt_mode = 0;
            if (m_mode == 3 && !irq_enable) nxt_mode = 0;
            if (ex_branch_taken) begin
                sq_if = 1; sq_id = 1;
            end else if (m_mode == 0 && irq_req && irq_enable && id_valid && !id_jump) begin
                take = 1; sq_if = 1; nxt_mode = 3;
            end else if (m_mode != 1 && lu) begin
                fr_lu = 1;
                if (m_mode == 0) nxt_mode = 1;
            end else if (m_mode != 1 && id_jump) begin
                sq_if = 1;
            end
        end
        exp_o.pc_write     = !(fr_mem || fr_lu);
        exp_o.if_id_write  = !(fr_mem || fr_lu);
        exp_o.if_id_flush  = sq_if;
        exp_o.id_ex_flush  = sq_id || fr_lu;
        exp_o.ex_mem_hold  = fr_mem;
        exp_o.mem_wb_flush = fr_mem || err;
        exp_o.irq_take     = take;
        exp_o.bus_err      = err;
        exp_o.state        = 2'(m_mode);
    endtask

    task automatic model_commit();
        m_mode   = nxt_mode;
        m_waited = nxt_waited;
        if (cnt_clr) m_stalls = 0;
        else if (!exp_o.pc_write && m_stalls < (2**CNT_W - 1)) m_stalls = m_stalls + 1;
    endtask

    task automatic compare(input string tag);
        got_o = {pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_hold,
                 mem_wb_flush, irq_take, bus_err, state};
        checks++;
        if (got_o !== exp_o) begin
            failures++;
            $display("FAIL ctl_%0s cyc=%0d got=%b required=%b", tag, cyc_no, got_o, exp_o);
        end
        checks++;
        if (stall_cycles !== CNT_W'(m_stalls)) begin
            failures++;
            $display("FAIL stall_%0s cyc=%0d got=%0d required=%0d", tag, cyc_no, stall_cycles, m_stalls);
        end
    endtask

    task automatic lit(input string name, input int got, input int req);
        checks++;
        if (got != req) begin
            failures++;
            $display("FAIL lit_%0s got=%0d required=%0d", name, got, req);
        end
    endtask

    // One pipeline cycle: drive at negedge, check mid-cycle, commit at posedge.
    task automatic cyc(input string tag, input vec_t vi);
        drive(vi);
        #2;
        model_eval();
        compare(tag);
        snap = got_o;
        $display("cyc %0d %-8s in=%h out=%b stall=%0d", cyc_no, tag, vi, got_o, stall_cycles);
        @(posedge clk);
        model_commit();
        cyc_no++;
        @(negedge clk);
    endtask

    vec_t idle, v;

    initial begin
        idle = '0;
        reset_b = 1'b0;
        drive(idle);
        model_reset();
        repeat (2) @(negedge clk);
        #2;
        lit("reset_state", int'(state), 0);
        lit("reset_stall", int'(stall_cycles), 0);
        model_eval();
        compare("reset");
        @(negedge clk);
        reset_b = 1'b1;

        cyc("idle", idle);

        // lw $1 in EX, add using rs=$1 in ID
        v = idle; v.id_valid = 1; v.id_rs = 1; v.id_rt = 2; v.id_uses_rt = 1;
        v.id_ex_memread = 1; v.id_ex_writereg = 1;
        cyc("lu_rs", v);
        lit("lu_pcw", int'(snap.pc_write), 0);
        lit("lu_ifw", int'(snap.if_id_write), 0);
        lit("lu_flush", int'(snap.id_ex_flush), 1);
        lit("lu_state", int'(state), 1);
        v = idle; v.id_valid = 1; v.id_rs = 1; v.id_rt = 2; v.id_uses_rt = 1;
        cyc("lu_after", v);
        lit("lu_after_pcw", int'(snap.pc_write), 1);
        lit("lu_stall1", int'(stall_cycles), 1);
        lit("lu_back_run", int'(state), 0);

        // rt matches but not used; then destination $0
        v = idle; v.id_valid = 1; v.id_rs = 3; v.id_rt = 1; v.id_uses_rt = 0;
        v.id_ex_memread = 1; v.id_ex_writereg = 1;
        cyc("rt_unused", v);
        lit("rt_unused_pcw", int'(snap.pc_write), 1);
        v = idle; v.id_valid = 1; v.id_rs = 0; v.id_ex_memread = 1; v.id_ex_writereg = 0;
        cyc("dest_zero", v);
        lit("dest_zero_pcw", int'(snap.pc_write), 1);

        // rt hazard together with counter clear
        v = idle; v.id_valid = 1; v.id_rs = 4; v.id_rt = 7; v.id_uses_rt = 1;
        v.id_ex_memread = 1; v.id_ex_writereg = 7; v.cnt_clr = 1;
        cyc("lu_rt_clr", v);
        lit("clr_pcw", int'(snap.pc_write), 0);
        lit("clr_wins", int'(stall_cycles), 0);
        cyc("lu_after2", idle);

        // memory wait: 3 cycles not ready, then ready
        v = idle; v.mem_req = 1;
        for (int i = 0; i < 3; i++) cyc("memwait", v);
        v.mem_ready = 1;
        cyc("memready", v);
        lit("mem_stall3", int'(stall_cycles), 3);
        lit("mem_run", int'(state), 0);

        // timeout with MAX_WAIT=4
        v = idle; v.mem_req = 1;
        for (int i = 0; i < 5; i++) begin
            cyc("timeout", v);
            if (i == 3) lit("berr_c3", int'(snap.bus_err), 0);
            if (i == 4) lit("berr_c4", int'(snap.bus_err), 1);
        end
        lit("berr_run", int'(state), 0);
        lit("berr_stalls", int'(stall_cycles), 7);
        cyc("idle", idle);

        // branch concurrent with load-use and IRQ
        v = idle; v.id_valid = 1; v.id_rs = 5; v.id_ex_memread = 1; v.id_ex_writereg = 5;
        v.ex_branch_taken = 1; v.irq_req = 1; v.irq_enable = 1;
        cyc("br_all", v);
        lit("br_pcw", int'(snap.pc_write), 1);
        lit("br_ifflush", int'(snap.if_id_flush), 1);
        lit("br_idflush", int'(snap.id_ex_flush), 1);
        lit("br_notake", int'(snap.irq_take), 0);
        v = idle; v.id_valid = 1; v.id_rs = 6; v.irq_req = 1; v.irq_enable = 1;
        cyc("irq_take", v);
        lit("irq_pulse", int'(snap.irq_take), 1);
        lit("irq_hold", int'(state), 3);
        cyc("irq_held", v);
        lit("irq_nopulse", int'(snap.irq_take), 0);
        cyc("irq_held", v);
        v.irq_enable = 0;
        cyc("kernel", v);
        lit("irq_exit", int'(state), 0);
        v.irq_enable = 1;
        cyc("irq_again", v);
        lit("irq_pulse2", int'(snap.irq_take), 1);
        v.irq_enable = 0;
        cyc("kernel", v);

        // IRQ deferred while a jump sits in ID
        v = idle; v.id_valid = 1; v.id_jump = 1; v.irq_req = 1; v.irq_enable = 1;
        cyc("irq_jump", v);
        lit("jump_defer", int'(snap.irq_take), 0);
        lit("jump_flush", int'(snap.if_id_flush), 1);
        v.id_jump = 0;
        cyc("irq_late", v);
        lit("late_take", int'(snap.irq_take), 1);
        v.irq_enable = 0;
        cyc("kernel", v);

        // asynchronous reset in the middle of a memory wait
        v = idle; v.mem_req = 1;
        cyc("memwait", v);
        cyc("memwait", v);
        #2;
        reset_b = 1'b0;
        #1;
        lit("areset_state", int'(state), 0);
        lit("areset_stall", int'(stall_cycles), 0);
        model_reset();
        drive(idle);
        @(negedge clk);
        reset_b = 1'b1;
        cyc("idle", idle);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
